// File: rtl/ping_scheduler_pkg.sv
// Shared types, default timing constants and the round-robin pick for the ultrasonic ping scheduler.
package ping_pkg;
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, REPORT, GAP} state_e;

  localparam int DEF_NUM_SENSORS    = 4;
  localparam int DEF_TRIG_CYCLES    = 500;
  localparam int DEF_TIMEOUT_CYCLES = 1_500_000;
  localparam int DEF_GAP_CYCLES     = 500_000;
  localparam int DEF_WIDTH_W        = 22;
  localparam int MAX_SENSORS        = 32;

  // First enabled sensor at index >= cur, wrapping at n; returns cur when mask is empty.
  function automatic int unsigned next_sensor(input logic [MAX_SENSORS-1:0] mask,
                                              input int unsigned n, input int unsigned cur);
    int unsigned idx;
    bit found;
    next_sensor = cur;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_SENSORS; i++) begin
      idx = cur + i;
      if (idx >= n) idx = idx - n;
      if (!found && i < n && mask[idx[4:0]]) begin
        next_sensor = idx;
        found = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/ping_scheduler_if.sv
// Result stream from the scheduler to the distance converter / display.
interface ping_scheduler_if #(
  parameter int NUM_SENSORS = 4,
  parameter int WIDTH_W     = 22
);
  localparam int SEL_W = $clog2(NUM_SENSORS);

  logic               meas_valid;
  logic               meas_ready;
  logic [SEL_W-1:0]   meas_sensor;
  logic [WIDTH_W-1:0] meas_width;
  logic               meas_timeout;

  modport master (output meas_valid, meas_sensor, meas_width, meas_timeout, input meas_ready);
  modport slave  (input meas_valid, meas_sensor, meas_width, meas_timeout, output meas_ready);
endinterface

// File: rtl/ping_scheduler_echo_sync.sv
// Two-flop synchroniser on the raw echo lines plus registered rise/fall pulses.
module echo_sync #(
  parameter int NUM_SENSORS = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] rise,
  output logic [NUM_SENSORS-1:0] fall
);
  logic [NUM_SENSORS-1:0] s1, s2, s3;

  // Both edges pass through the same three stages, so measured width is not skewed.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1   <= '0;
      s2   <= '0;
      s3   <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      s1   <= echo;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end
endmodule

// File: rtl/ping_scheduler.sv
// Round-robin ultrasonic ping sequencer: trigger, time echo width, report on a valid/ready stream.
module ping_scheduler
  import ping_pkg::*;
#(
  parameter int NUM_SENSORS    = DEF_NUM_SENSORS,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int WIDTH_W        = DEF_WIDTH_W
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] en_mask,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trigger,
  output logic                   busy,
  ping_scheduler_if.master       meas
);
  localparam int SEL_W = $clog2(NUM_SENSORS);

  state_e             state, state_nxt;
  logic [WIDTH_W-1:0] cnt, cnt_inc;
  logic [SEL_W-1:0]   sel, sel_first, sel_adv;
  logic [NUM_SENSORS-1:0] rise, fall;
  logic start_ok, trig_done, wait_to, meas_sat, gap_done, rise_sel, fall_sel;

  echo_sync #(.NUM_SENSORS(NUM_SENSORS)) u_sync (
    .clock(clock), .reset_n(reset_n), .echo(echo), .rise(rise), .fall(fall)
  );

  // The single counter is shared by every timed state and saturates instead of wrapping.
  always_comb begin
    cnt_inc   = (&cnt) ? cnt : cnt + 1'b1;
    start_ok  = enable && (|en_mask);
    trig_done = (cnt == WIDTH_W'(TRIG_CYCLES - 1));
    wait_to   = (cnt_inc == WIDTH_W'(TIMEOUT_CYCLES));
    meas_sat  = (cnt_inc >= WIDTH_W'(TIMEOUT_CYCLES));
    gap_done  = (cnt == WIDTH_W'(GAP_CYCLES - 1));
    rise_sel  = rise[sel];
    fall_sel  = fall[sel];
    sel_first = SEL_W'(next_sensor(MAX_SENSORS'(en_mask), NUM_SENSORS, 32'(sel)));
    sel_adv   = SEL_W'(next_sensor(MAX_SENSORS'(en_mask), NUM_SENSORS,
                       (32'(sel) == NUM_SENSORS - 1) ? 32'd0 : 32'(sel) + 32'd1));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start_ok) state_nxt = TRIG;
      TRIG:      if (trig_done) state_nxt = WAIT_RISE;
      WAIT_RISE: if (rise_sel) state_nxt = MEASURE;
                 else if (wait_to) state_nxt = REPORT;
      MEASURE:   if (meas_sat || fall_sel) state_nxt = REPORT;
      REPORT:    if (meas.meas_ready) state_nxt = GAP;
      GAP:       if (gap_done) state_nxt = start_ok ? TRIG : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    trigger = '0;
    if (state == TRIG) trigger[sel] = 1'b1;
    meas.meas_valid = (state == REPORT);
    busy            = (state != IDLE);
  end

  // Result fields are written only when leaving WAIT_RISE/MEASURE, so they hold through REPORT.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt               <= '0;
      sel               <= '0;
      meas.meas_sensor  <= '0;
      meas.meas_width   <= '0;
      meas.meas_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start_ok) sel <= sel_first;
        end
        TRIG: cnt <= trig_done ? '0 : cnt_inc;
        WAIT_RISE: begin
          cnt <= rise_sel ? '0 : cnt_inc;
          if (!rise_sel && wait_to) begin
            meas.meas_sensor  <= sel;
            meas.meas_width   <= '0;
            meas.meas_timeout <= 1'b1;
          end
        end
        MEASURE: begin
          cnt <= cnt_inc;
          if (meas_sat) begin
            meas.meas_sensor  <= sel;
            meas.meas_width   <= WIDTH_W'(TIMEOUT_CYCLES);
            meas.meas_timeout <= 1'b1;
          end else if (fall_sel) begin
            // The fall clock itself is the last high cycle of the echo.
            meas.meas_sensor  <= sel;
            meas.meas_width   <= cnt_inc;
            meas.meas_timeout <= 1'b0;
          end
        end
        REPORT: cnt <= '0;
        GAP: begin
          cnt <= gap_done ? '0 : cnt_inc;
          if (gap_done) sel <= sel_adv;
        end
        default: cnt <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_ping_scheduler.sv
// Directed bench for ping_scheduler: scoreboard queue of expected results checked by a stream monitor.
module tb_ping_scheduler;
  localparam int NS = 4, TRIG = 5, TO = 100, GAP = 10, WW = 8;

  typedef struct {
    int sensor;
    int width;
    bit to;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n, enable;
  logic [NS-1:0] en_mask, stray, resp_on, trigger, held_trig;
  wire  [NS-1:0] echo;
  logic busy;
  int resp_delay, resp_len;

  int n_chk = 0, n_pass = 0, n_hs = 0, cyc = 0, hs_edge = 0, trig_edge = 0, bad_onehot = 0;
  int trig_cnt [NS] = '{default: 0};
  int trig_len [NS] = '{default: 0};
  int snap [NS];
  logic [NS-1:0] trig_prev = '0;
  exp_t q[$];
  exp_t mon_e;

  ping_scheduler_if #(.NUM_SENSORS(NS), .WIDTH_W(WW)) mif ();

  ping_scheduler #(.NUM_SENSORS(NS), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TO),
                   .GAP_CYCLES(GAP), .WIDTH_W(WW)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .en_mask(en_mask), .echo(echo),
    .trigger(trigger), .busy(busy), .meas(mif.master)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Echo model: after a trigger falls, sensor g answers resp_delay clocks later for resp_len clocks.
  for (genvar g = 0; g < NS; g++) begin : g_resp
    logic e;
    initial begin
      e = 1'b0;
      forever begin
        @(negedge trigger[g]);
        if (resp_on[g]) begin
          repeat (resp_delay) @(posedge clock);
          #1 e = 1'b1;
          repeat (resp_len) @(posedge clock);
          #1 e = 1'b0;
        end
      end
    end
    assign echo[g] = e | stray[g];
  end

  task automatic check(input string name, input bit ok, input string detail);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  task automatic chk_val(input string name, input longint act, input longint exp);
    check(name, act == exp, $sformatf("got %0d, expected %0d", act, exp));
  endtask

  task automatic push(input int s, input int w, input bit t);
    exp_t e;
    e.sensor = s; e.width = w; e.to = t;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_hs(input int target, input int budget);
    int k = 0;
    while (n_hs < target && k < budget) begin tick(); k++; end
    if (n_hs < target) check("wait_result", 1'b0, $sformatf("got %0d results, expected %0d", n_hs, target));
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin tick(); k++; end
    chk_val("idle_busy", busy, 0);
  endtask

  task automatic wait_trig(input int budget);
    int k = 0;
    while (trigger == '0 && k < budget) begin tick(); k++; end
    if (trigger == '0) check("wait_trigger", 1'b0, "got no trigger, expected one");
  endtask

  task automatic do_reset();
    int k = 0;
    enable = 1'b0;
    while (echo != '0 && k < 400) begin tick(); k++; end
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic take_snap();
    for (int i = 0; i < NS; i++) snap[i] = trig_cnt[i];
  endtask

  // Result stream monitor: every accepted beat is compared with the head of the scoreboard.
  always @(negedge clock) begin
    if (reset_n && mif.meas_valid && mif.meas_ready) begin
      if (q.size() == 0) begin
        check("unexpected_result", 1'b0, $sformatf("got s=%0d w=%0d to=%0d, expected none",
              mif.meas_sensor, mif.meas_width, mif.meas_timeout));
      end else begin
        mon_e = q.pop_front();
        check("result", mif.meas_sensor == mon_e.sensor && mif.meas_width == mon_e.width &&
              mif.meas_timeout == mon_e.to,
              $sformatf("got s=%0d w=%0d to=%0d, expected s=%0d w=%0d to=%0d",
              mif.meas_sensor, mif.meas_width, mif.meas_timeout, mon_e.sensor, mon_e.width, mon_e.to));
      end
      n_hs++;
      hs_edge = cyc + 1;  // the handshake completes on the coming posedge
    end
  end

  // Trigger monitor: pulse length per sensor, pulse counts, one-hot property.
  always @(negedge clock) begin
    if (!$onehot0(trigger)) bad_onehot++;
    for (int i = 0; i < NS; i++) begin
      if (trigger[i]) begin
        if (!trig_prev[i]) begin
          trig_cnt[i]++;
          trig_len[i] = 1;
          trig_edge = cyc;
        end else trig_len[i]++;
      end else if (trig_prev[i]) begin
        chk_val($sformatf("trig_len_%0d", i), trig_len[i], TRIG);
      end
    end
    trig_prev = trigger;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no end of run, expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    logic [WW-1:0] hw;
    logic [1:0] hs;
    logic ht;
    bit stall_ok;
    reset_n = 1'b0; enable = 1'b0; en_mask = '0; stray = '0; resp_on = '0;
    resp_delay = 20; resp_len = 37; mif.meas_ready = 1'b1;
    repeat (3) tick();
    chk_val("rst_busy", busy, 0);
    chk_val("rst_valid", mif.meas_valid, 0);
    chk_val("rst_trigger", trigger, 0);
    chk_val("rst_result", {mif.meas_sensor, mif.meas_width, mif.meas_timeout}, 0);
    reset_n = 1'b1;
    tick();

    // 1: all four sensors answer with a 37-clock echo
    base = n_hs; take_snap();
    push(0, 37, 0); push(1, 37, 0); push(2, 37, 0); push(3, 37, 0); push(0, 37, 0);
    resp_on = 4'b1111; en_mask = 4'b1111; enable = 1'b1;
    wait_hs(base + 5, 3000);
    enable = 1'b0;
    wait_idle(100);
    chk_val("p1_trig_s0", trig_cnt[0] - snap[0], 2);
    chk_val("p1_trig_s3", trig_cnt[3] - snap[3], 1);

    // 2: sparse mask, nobody answers
    do_reset();
    base = n_hs; take_snap();
    push(0, 0, 1); push(2, 0, 1); push(0, 0, 1);
    resp_on = '0; en_mask = 4'b0101; enable = 1'b1;
    wait_hs(base + 3, 1000);
    enable = 1'b0;
    wait_idle(100);
    chk_val("p2_trig_s1", trig_cnt[1] - snap[1], 0);
    chk_val("p2_trig_s3", trig_cnt[3] - snap[3], 0);
    chk_val("p2_trig_s2", trig_cnt[2] - snap[2], 1);

    // 3: over-long echo saturates; gap to next trigger
    do_reset();
    base = n_hs;
    push(0, 100, 1); push(1, 0, 1);
    resp_on = 4'b0001; resp_len = 200; en_mask = 4'b0011; enable = 1'b1;
    wait_hs(base + 1, 500);
    wait_trig(50);
    @(negedge clock); #1;
    chk_val("p3_gap", trig_edge - hs_edge, GAP);
    chk_val("p3_next_sensor", trigger, 4'b0010);
    enable = 1'b0;
    wait_hs(base + 2, 500);
    wait_idle(100);
    resp_len = 37;

    // 4: back-pressure in REPORT
    do_reset();
    base = n_hs;
    push(0, 37, 0);
    resp_on = 4'b0001; en_mask = 4'b0001; mif.meas_ready = 1'b0; enable = 1'b1;
    begin
      int k = 0;
      while (!mif.meas_valid && k < 500) begin tick(); k++; end
    end
    chk_val("p4_valid", mif.meas_valid, 1);
    hs = mif.meas_sensor; hw = mif.meas_width; ht = mif.meas_timeout;
    stall_ok = 1'b1;
    repeat (50) begin
      tick();
      if (!mif.meas_valid || mif.meas_sensor != hs || mif.meas_width != hw ||
          mif.meas_timeout != ht || trigger != '0) stall_ok = 1'b0;
    end
    check("p4_stall_hold", stall_ok, $sformatf("got stable=%0d, expected 1", stall_ok));
    mif.meas_ready = 1'b1; enable = 1'b0;
    wait_hs(base + 1, 20);
    wait_idle(100);

    // 5: reset during MEASURE of sensor 1
    do_reset();
    base = n_hs;
    push(0, 37, 0);
    resp_on = 4'b1111; en_mask = 4'b1111; enable = 1'b1;
    wait_hs(base + 1, 500);
    begin
      int k = 0;
      while (!echo[1] && k < 500) begin tick(); k++; end
    end
    repeat (8) tick();
    reset_n = 1'b0;
    tick();
    chk_val("p5_busy", busy, 0);
    chk_val("p5_valid", mif.meas_valid, 0);
    chk_val("p5_trigger", trigger, 0);
    chk_val("p5_result", {mif.meas_sensor, mif.meas_width, mif.meas_timeout}, 0);
    repeat (40) tick();
    push(0, 37, 0);
    reset_n = 1'b1;
    wait_trig(20);
    chk_val("p5_restart_sensor", trigger, 4'b0001);
    enable = 1'b0;
    wait_hs(base + 2, 500);
    wait_idle(100);

    // 6: enable drops in WAIT_RISE, stray echo on sensor 2
    do_reset();
    base = n_hs;
    push(0, 37, 0);
    resp_on = 4'b0001; en_mask = 4'b0001; enable = 1'b1;
    wait_trig(20);
    begin
      int k = 0;
      while (trigger != '0 && k < 20) begin tick(); k++; end
    end
    repeat (5) tick();
    enable = 1'b0;
    begin
      int k = 0;
      while (!echo[0] && k < 100) begin tick(); k++; end
    end
    repeat (10) tick();
    stray[2] = 1'b1;
    repeat (6) tick();
    stray[2] = 1'b0;
    wait_hs(base + 1, 500);
    wait_idle(100);
    take_snap();
    repeat (40) tick();
    chk_val("p6_no_retrigger", (trig_cnt[0] - snap[0]) + (trig_cnt[2] - snap[2]), 0);
    chk_val("p6_still_idle", busy, 0);

    chk_val("queue_empty", q.size(), 0);
    chk_val("trigger_onehot", bad_onehot, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
